fp32_seq_subtractor: RTL and testbench

- Multi-cycle IEEE-754 single-precision subtractor that computes D = A − B. It is the inverse operation to the team's combinational FP32 adder.
- Internally it negates B's sign, then aligns, adds or subtracts magnitudes, and normalizes, one shift per clock. This removes the deep combinational shifters.
- It sits beside the FP32 adder/multiplier blocks in the arithmetic datapath and uses a valid/ready handshake on both input and output.

---
 rtl/fp32_pkg.sv | 48 ++++
 rtl/fp32_norm_shifter.sv | 65 ++++++
 rtl/fp32_seq_subtractor.sv | 173 +++++++++++++++++
 tb/tb_fp32_seq_subtractor.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the sequential arithmetic blocks.
// Holds field widths, the subtractor FSM state encoding, result flag bit
// positions and small pack/unpack helpers.
package fp32_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;
  localparam int BIAS = 127;

  localparam int FLAG_OVF  = 2;
  localparam int FLAG_UNF  = 1;
  localparam int FLAG_ZERO = 0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ALIGN  = 3'd1,
    ADDSUB = 3'd2,
    NORM   = 3'd3,
    DONE   = 3'd4
  } state_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  function automatic fp32_t fp32_unpack(input logic [31:0] x);
    fp32_t f;
    f.sign = x[31];
    f.exp  = x[30:23];
    f.man  = x[22:0];
    return f;
  endfunction

  function automatic logic [31:0] fp32_pack(input logic sign,
                                            input logic [EXP_W-1:0] exp,
                                            input logic [MAN_W-1:0] man);
    return {sign, exp, man};
  endfunction

  // 24-bit significand; exp=0 operands carry no hidden bit.
  function automatic logic [MAN_W:0] fp32_sig(input fp32_t f);
    return {|f.exp, f.man};
  endfunction

endpackage

// File: rtl/fp32_norm_shifter.sv
// Single-step normalizer register stage.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   load          capture load_man/load_exp (raw 25-bit sum and its exponent)
//   load_man      25-bit magnitude, bit 24 is the carry position
//   load_exp      exponent belonging to load_man
//   step          advance one normalization step (left shift) when not finished
//   res_frac      23-bit fraction of the normalized result
//   res_exp       exponent of the normalized result
//   finish        current contents resolve to a final result this cycle
//   ovf / unf     final result overflows to Inf / underflows to zero
module fp32_norm_shifter
  import fp32_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [MAN_W+1:0] load_man,
  input  logic [EXP_W-1:0] load_exp,
  input  logic             step,
  output logic [MAN_W-1:0] res_frac,
  output logic [EXP_W-1:0] res_exp,
  output logic             finish,
  output logic             ovf,
  output logic             unf
);

  logic [MAN_W+1:0] man_q;
  logic [EXP_W-1:0] exp_q;
  logic             carry;
  logic             normal;
  logic             at_floor;

  assign carry    = man_q[MAN_W+1];
  assign normal   = man_q[MAN_W];
  // Another left shift would take the exponent below 1.
  assign at_floor = (exp_q <= 8'd1);

  assign finish   = carry || normal || at_floor;
  // Carry resolves in one step: the incremented exponent hitting 255 is overflow.
  assign ovf      = carry && (exp_q >= (EXP_MAX - 8'd1));
  assign unf      = !carry && !normal && at_floor;

  assign res_frac = carry ? man_q[MAN_W:1] : man_q[MAN_W-1:0];
  assign res_exp  = carry ? (exp_q + 8'd1) : exp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      man_q <= '0;
      exp_q <= '0;
    end else if (load) begin
      man_q <= load_man;
      exp_q <= load_exp;
    end else if (step) begin
      if (carry) begin
        man_q <= man_q >> 1;
        exp_q <= exp_q + 8'd1;
      end else if (!finish) begin
        man_q <= man_q << 1;
        exp_q <= exp_q - 8'd1;
      end
    end
  end

endmodule

// File: rtl/fp32_seq_subtractor.sv
// Multi-cycle FP32 subtractor, d = a - b, one shift per clock.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (a, b sampled on accept only)
//   a, b                 minuend, subtrahend
//   out_valid / out_ready result handshake, d/flags held until accepted
//   d                    result
//   flags                {overflow, underflow, zero}
//
// state  | meaning
// IDLE   | ready for operands
// ALIGN  | shifting the smaller significand right, one bit per cycle
// ADDSUB | add or subtract aligned significands
// NORM   | one normalization step per cycle
// DONE   | result presented, waiting for out_ready
module fp32_seq_subtractor
  import fp32_pkg::*;
#(
  parameter int MAX_ALIGN = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d,
  output logic [2:0]  flags
);

  state_e state_q, state_d;

  logic [MAN_W:0]   large_man_q, small_man_q;
  logic [EXP_W-1:0] exp_q;
  logic [EXP_W-1:0] shift_cnt_q;
  logic             sign_l_q, sign_s_q;
  logic [31:0]      d_q;
  logic [2:0]       flags_q;

  fp32_t            op_a, op_b;
  logic             a_larger;
  logic             align_clear;
  logic [MAN_W+1:0] sum;
  logic             sum_zero;
  logic             ns_load, ns_step;
  logic [MAN_W-1:0] ns_frac;
  logic [EXP_W-1:0] ns_exp;
  logic             ns_finish, ns_ovf, ns_unf;

  assign op_a = fp32_unpack(a);
  assign op_b = fp32_unpack(b);

  // Equal operands go to B so the zero result takes B's effective sign path.
  assign a_larger = (op_a.exp > op_b.exp) ||
                    ((op_a.exp == op_b.exp) && (op_a.man > op_b.man));

  assign align_clear = (shift_cnt_q >= EXP_W'(MAX_ALIGN));

  // large >= small after alignment, so the difference never goes negative.
  assign sum = (sign_l_q == sign_s_q) ? ({1'b0, large_man_q} + {1'b0, small_man_q})
                                      : ({1'b0, large_man_q} - {1'b0, small_man_q});
  assign sum_zero = (sum == '0);

  fp32_norm_shifter u_norm (
    .clk      (clk),
    .rst      (rst),
    .load     (ns_load),
    .load_man (sum),
    .load_exp (exp_q),
    .step     (ns_step),
    .res_frac (ns_frac),
    .res_exp  (ns_exp),
    .finish   (ns_finish),
    .ovf      (ns_ovf),
    .unf      (ns_unf)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)            state_d = ALIGN;
      ALIGN:   if (shift_cnt_q == '0)   state_d = ADDSUB;
      ADDSUB:  state_d = sum_zero ? DONE : NORM;
      NORM:    if (ns_finish)           state_d = DONE;
      DONE:    if (out_ready)           state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    ns_load   = (state_q == ADDSUB);
    ns_step   = (state_q == NORM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      large_man_q <= '0;
      small_man_q <= '0;
      exp_q       <= '0;
      shift_cnt_q <= '0;
      sign_l_q    <= 1'b0;
      sign_s_q    <= 1'b0;
      d_q         <= '0;
      flags_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (a_larger) begin
              large_man_q <= fp32_sig(op_a);
              small_man_q <= fp32_sig(op_b);
              exp_q       <= op_a.exp;
              sign_l_q    <= op_a.sign;
              sign_s_q    <= ~op_b.sign;
              shift_cnt_q <= op_a.exp - op_b.exp;
            end else begin
              large_man_q <= fp32_sig(op_b);
              small_man_q <= fp32_sig(op_a);
              exp_q       <= op_b.exp;
              sign_l_q    <= ~op_b.sign;
              sign_s_q    <= op_a.sign;
              shift_cnt_q <= op_b.exp - op_a.exp;
            end
          end
        end
        ALIGN: begin
          if (align_clear) begin
            small_man_q <= '0;
            shift_cnt_q <= '0;
          end else if (shift_cnt_q != '0) begin
            small_man_q <= small_man_q >> 1;
            shift_cnt_q <= shift_cnt_q - 8'd1;
          end
        end
        ADDSUB: begin
          if (sum_zero) begin
            d_q                <= '0;
            flags_q            <= '0;
            flags_q[FLAG_ZERO] <= 1'b1;
          end
        end
        NORM: begin
          if (ns_finish) begin
            flags_q <= '0;
            if (ns_ovf) begin
              d_q               <= fp32_pack(sign_l_q, EXP_MAX, '0);
              flags_q[FLAG_OVF] <= 1'b1;
            end else if (ns_unf) begin
              d_q               <= '0;
              flags_q[FLAG_UNF] <= 1'b1;
            end else begin
              d_q <= fp32_pack(sign_l_q, ns_exp, ns_frac);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign d     = d_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_fp32_seq_subtractor.sv
module tb_fp32_seq_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d;
  logic [2:0]  flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp32_seq_subtractor #(.MAX_ALIGN(25)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .flags     (flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits for out_valid after an accept; returns the number of edges taken.
  task automatic wait_result(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                        input logic [31:0] exp_d, input logic [2:0] exp_flags,
                        input int exp_lat);
    int n;
    @(negedge clk);
    a        = op_a;
    b        = op_b;
    in_valid = 1'b1;
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    a        = 32'hDEAD_BEEF;
    b        = 32'h1234_5678;
    wait_result(tag, n);
    check({tag, "_d"}, d, exp_d);
    check({tag, "_flags"}, {29'b0, flags}, {29'b0, exp_flags});
    if (exp_lat >= 0) check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_release"}, {30'b0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    int n;
    logic [31:0] held_d;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("reset_in_ready",  {31'b0, in_ready},  32'd1);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_d",         d,                  32'd0);
    check("reset_flags",     {29'b0, flags},     32'd0);

    // 3.0 - 1.0 = 2.0
    run_op("three_minus_one", 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 3'b000, -1);
    // 1.0 - 1.0 = +0, zero flag
    run_op("one_minus_one",   32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 3'b001, -1);
    // -1.0 - -1.0 = +0
    run_op("neg_minus_neg",   32'hBF80_0000, 32'hBF80_0000, 32'h0000_0000, 3'b001, -1);
    // 1.0 - (-1.0) = 2.0 through the carry path
    run_op("carry_path",      32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 3'b000, -1);
    // 1.0 - (1 - 2^-24): truncated LSB leaves 2^-23, 1 align + 23 left shifts
    run_op("trunc_2m23",      32'h3F80_0000, 32'h3F7F_FFFF, 32'h3400_0000, 3'b000, 27);
    // max + max -> +Inf, overflow
    run_op("overflow",        32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 3'b100, -1);
    // 1.0 - 2.0 = -1.0
    run_op("neg_result",      32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 3'b000, -1);
    // min normal - denormal: normalizing would drop exp below 1
    run_op("underflow",       32'h0080_0000, 32'h0040_0000, 32'h0000_0000, 3'b010, -1);
    // exponent gap 25 clears the small operand in one cycle
    run_op("align_cap",       32'h4C00_0000, 32'h3F80_0000, 32'h4C00_0000, 3'b000, 4);
    // 2^23 - 1: 23 align shifts, 1 left shift
    run_op("diff23",          32'h4B00_0000, 32'h3F80_0000, 32'h4AFF_FFFE, 3'b000, 27);

    // Back-pressure: hold out_ready low, offer new operands, nothing may move.
    @(negedge clk);
    a        = 32'h3F80_0000;
    b        = 32'hBF80_0000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_result("stall", n);
    held_d = 32'h4000_0000;
    a        = 32'h4040_0000;
    b        = 32'h3F80_0000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_d",         d,                  held_d);
      check("stall_out_valid", {31'b0, out_valid}, 32'd1);
      check("stall_in_ready",  {31'b0, in_ready},  32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("stall_release", {30'b0, in_ready, out_valid}, 32'd2);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("stall_no_ghost", {30'b0, in_ready, out_valid}, 32'd2);
    end

    // Reset while aligning aborts the operation.
    @(negedge clk);
    a        = 32'h4B00_0000;
    b        = 32'h3F80_0000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", {31'b0, out_valid}, 32'd0);
    check("abort_in_ready",  {31'b0, in_ready},  32'd1);
    check("abort_d",         d,                  32'd0);
    run_op("after_abort", 32'h4B00_0000, 32'h3F80_0000, 32'h4AFF_FFFE, 3'b000, 27);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
